// File: rtl/keypad_pkg.sv
// Types and helpers shared by the keypad scanner and its event FIFO.
package keypad_pkg;

  // Classification of one full matrix scan, and of the debounced state.
  typedef enum logic [1:0] {
    ScanNone,
    ScanSingle,
    ScanMulti
  } scan_state_e;

  // Width needed to encode n distinct values, never less than one bit.
  function automatic int unsigned key_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO for key events; a push into a full FIFO without a
// simultaneous pop is dropped and flagged on overflow_o.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW = key_width(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o    = (cnt_q == '0);
  assign full       = (cnt_q == CntW'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push    = push_i & (~full | do_pop);
  assign overflow_o = push_i & full & ~do_pop;
  assign head_o     = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives columns in turn, classifies each full scan,
// debounces the classification and queues newly accepted single keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 62500,
  parameter int unsigned DEBOUNCE   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned KEY_W     = key_width(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_held,
  output logic             multi_key,
  output logic             overflow
);

  localparam int unsigned DivW = key_width(SCAN_DIV);
  localparam int unsigned ColW = key_width(COLS);
  localparam int unsigned DebW = $clog2(DEBOUNCE + 1);

  logic [ROWS-1:0]  row_meta_q, row_sync_q;
  logic [DivW-1:0]  div_q, div_d;
  logic [ColW-1:0]  col_q, col_d;
  // Keys seen so far this scan: 0, 1 or 2 meaning "more than one".
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [KEY_W-1:0] acc_code_q, acc_code_d;
  scan_state_e      cand_state_q, cand_state_d;
  logic [KEY_W-1:0] cand_code_q, cand_code_d;
  logic [DebW-1:0]  cand_cnt_q, cand_cnt_d;
  scan_state_e      deb_state_q, deb_state_d;
  logic [KEY_W-1:0] deb_code_q, deb_code_d;
  logic             push_q, push_d;

  logic             col_last;
  logic             scan_end;
  logic [1:0]       smp_cnt;
  logic [KEY_W-1:0] smp_code;
  scan_state_e      cls_state;
  logic [KEY_W-1:0] cls_code;
  logic             fifo_empty;

  // Rows are asynchronous to clk; idle (released) level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
    end
  end

  assign col_last = (div_q == DivW'(SCAN_DIV - 1));
  assign scan_end = col_last && (col_q == ColW'(COLS - 1));
  assign col_out  = ~(COLS'(1) << col_q);

  always_comb begin
    div_d = col_last ? '0 : div_q + DivW'(1);
    col_d = col_q;
    if (col_last) begin
      col_d = scan_end ? '0 : col_q + ColW'(1);
    end
  end

  // Fold the current column's rows into the running scan tally.
  always_comb begin
    smp_cnt  = acc_cnt_q;
    smp_code = acc_code_q;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sync_q[r]) begin
        if (smp_cnt == 2'd0) begin
          smp_code = KEY_W'(r * COLS) + KEY_W'(col_q);
        end
        smp_cnt = (smp_cnt == 2'd0) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    cls_state = ScanNone;
    cls_code  = '0;
    unique case (smp_cnt)
      2'd0:    cls_state = ScanNone;
      2'd1: begin
        cls_state = ScanSingle;
        cls_code  = smp_code;
      end
      default: cls_state = ScanMulti;
    endcase
  end

  always_comb begin
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (col_last) begin
      acc_cnt_d  = scan_end ? '0 : smp_cnt;
      acc_code_d = scan_end ? '0 : smp_code;
    end
  end

  always_comb begin
    cand_state_d = cand_state_q;
    cand_code_d  = cand_code_q;
    cand_cnt_d   = cand_cnt_q;
    deb_state_d  = deb_state_q;
    deb_code_d   = deb_code_q;
    push_d       = 1'b0;
    if (scan_end) begin
      if (cls_state == cand_state_q && cls_code == cand_code_q) begin
        if (cand_cnt_q < DebW'(DEBOUNCE)) begin
          cand_cnt_d = cand_cnt_q + DebW'(1);
        end
      end else begin
        cand_state_d = cls_state;
        cand_code_d  = cls_code;
        cand_cnt_d   = DebW'(1);
      end
      if (cand_cnt_d >= DebW'(DEBOUNCE)) begin
        deb_state_d = cand_state_d;
        deb_code_d  = cand_code_d;
        // Only a change into a (different) single key is a new event.
        push_d = (cand_state_d == ScanSingle) &&
                 (deb_state_q != ScanSingle || deb_code_q != cand_code_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      col_q        <= '0;
      acc_cnt_q    <= '0;
      acc_code_q   <= '0;
      cand_state_q <= ScanNone;
      cand_code_q  <= '0;
      cand_cnt_q   <= '0;
      deb_state_q  <= ScanNone;
      deb_code_q   <= '0;
      push_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      col_q        <= col_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_code_q   <= acc_code_d;
      cand_state_q <= cand_state_d;
      cand_code_q  <= cand_code_d;
      cand_cnt_q   <= cand_cnt_d;
      deb_state_q  <= deb_state_d;
      deb_code_q   <= deb_code_d;
      push_q       <= push_d;
    end
  end

  assign key_held  = (deb_state_q == ScanSingle);
  assign multi_key = (deb_state_q == ScanMulti);
  assign key_valid = ~fifo_empty;

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_key_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_q),
    .push_data_i (deb_code_q),
    .pop_i       (key_ready),
    .head_o      (key_code),
    .empty_o     (fifo_empty),
    .overflow_o  (overflow)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model pulls rows low for pressed
// keys on the driven column; table vectors plus hand-written corner sequences.
module tb_keypad_scanner;

  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEBOUNCE   = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SCAN       = COLS * SCAN_DIV;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_ready;
  logic            key_held;
  logic            multi_key;
  logic            overflow;
  logic [15:0]     keys;
  logic [3:0]      exp_col;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .SCAN_DIV   (SCAN_DIV),
    .DEBOUNCE   (DEBOUNCE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .multi_key (multi_key),
    .overflow  (overflow)
  );

  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!col_out[c] && keys[r*COLS+c]) row_in[r] = 1'b0;
      end
    end
  end

  logic [3:0] popped[$];
  int         ovf_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && key_ready) popped.push_back(key_code);
      if (overflow) ovf_cnt++;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          scans;
    logic        ready;
    logic        held;
    logic        multi;
    logic        valid;
    logic [3:0]  code;
    int          npop;
    logic [15:0] pops;
    int          novf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [15:0] k, input int scans,
                              input logic ready, input logic held, input logic multi,
                              input logic valid, input logic [3:0] code, input int npop,
                              input logic [15:0] pops, input int novf);
    vec_t v;
    v.name  = name;  v.keys  = k;     v.scans = scans; v.ready = ready;
    v.held  = held;  v.multi = multi; v.valid = valid; v.code  = code;
    v.npop  = npop;  v.pops  = pops;  v.novf  = novf;
    vecs.push_back(v);
  endfunction

  initial begin
    int          p0;
    int          o0;
    logic [19:0] exp_order;

    keys      = '0;
    key_ready = 1'b0;
    rst_n     = 1'b0;

    //   name        keys      sc rdy held mul val code npop pops      ovf
    add("press6",    16'h0040, 3, 1, 1, 0, 0, 4'h0, 1, 16'h0006, 0);
    add("rel6a",     16'h0000, 1, 1, 1, 0, 0, 4'h0, 0, 16'h0000, 0);
    add("rel6b",     16'h0000, 2, 1, 0, 0, 0, 4'h0, 0, 16'h0000, 0);
    add("glitch6",   16'h0040, 1, 1, 0, 0, 0, 4'h0, 0, 16'h0000, 0);
    add("glitchrel", 16'h0000, 3, 1, 0, 0, 0, 4'h0, 0, 16'h0000, 0);
    add("multi",     16'h8001, 3, 1, 0, 1, 0, 4'h0, 0, 16'h0000, 0);
    add("rel33",     16'h0001, 3, 1, 1, 0, 0, 4'h0, 1, 16'h0000, 0);
    add("relall",    16'h0000, 3, 1, 0, 0, 0, 4'h0, 0, 16'h0000, 0);
    add("fill1",     16'h0002, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("fill2",     16'h0004, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("fill3",     16'h0008, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("fill4",     16'h0010, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("ovf5",      16'h0020, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 1);
    add("drain",     16'h0000, 3, 1, 0, 0, 0, 4'h0, 4, 16'h4321, 0);
    add("refill1",   16'h0002, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("refill2",   16'h0004, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("refill3",   16'h0008, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);
    add("refill4",   16'h0010, 3, 0, 1, 0, 1, 4'h1, 0, 16'h0000, 0);

    // Reset values, and the column counter frozen while reset is held.
    step(3);
    check("rst col_out", col_out, 4'b1110);
    check("rst key_valid", key_valid, 1'b0);
    check("rst key_code", key_code, 4'h0);
    check("rst key_held", key_held, 1'b0);
    check("rst multi_key", multi_key, 1'b0);
    check("rst overflow", overflow, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < int'(SCAN); i++) begin
      if (i % SCAN_DIV == 0) begin
        exp_col = ~(4'b0001 << (i / SCAN_DIV));
        check("col_out sequence", col_out, exp_col);
      end
      step(1);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v         = vecs[i];
      p0        = popped.size();
      o0        = ovf_cnt;
      keys      = v.keys;
      key_ready = v.ready;
      step(v.scans * SCAN);
      check({v.name, " key_held"}, key_held, v.held);
      check({v.name, " multi_key"}, multi_key, v.multi);
      check({v.name, " key_valid"}, key_valid, v.valid);
      check({v.name, " key_code"}, key_code, v.code);
      check({v.name, " pop count"}, popped.size() - p0, v.npop);
      for (int k = 0; k < v.npop; k++) begin
        if (p0 + k < popped.size()) check({v.name, " pop code"}, popped[p0+k], v.pops[4*k +: 4]);
      end
      check({v.name, " overflow pulses"}, ovf_cnt - o0, v.novf);
    end

    // Full FIFO, consumer ready in the very cycle key 9 is pushed.
    p0        = popped.size();
    o0        = ovf_cnt;
    keys      = 16'h0200;
    key_ready = 1'b0;
    step(2 * SCAN);
    check("full9 key_valid", key_valid, 1'b1);
    key_ready = 1'b1;
    step(SCAN);
    check("full9 overflow pulses", ovf_cnt - o0, 0);
    check("full9 pop count", popped.size() - p0, 5);
    exp_order = 20'h94321;
    for (int k = 0; k < 5; k++) begin
      if (p0 + k < popped.size()) check("full9 pop order", popped[p0+k], exp_order[4*k +: 4]);
    end
    check("full9 drained", key_valid, 1'b0);

    // Reset in column 2 of a debouncing press discards everything.
    keys      = 16'h0000;
    key_ready = 1'b1;
    step(3 * SCAN);
    key_ready = 1'b0;
    keys      = 16'h0040;
    step(3 * SCAN);
    check("pre-rst key_held", key_held, 1'b1);
    check("pre-rst key_code", key_code, 4'h6);
    keys = 16'h0080;
    step(SCAN + 2 * SCAN_DIV + 1);
    check("pre-rst col_out", col_out, 4'b1011);
    rst_n = 1'b0;
    #1;
    check("midrst col_out", col_out, 4'b1110);
    check("midrst key_valid", key_valid, 1'b0);
    check("midrst key_code", key_code, 4'h0);
    check("midrst key_held", key_held, 1'b0);
    check("midrst multi_key", multi_key, 1'b0);
    check("midrst overflow", overflow, 1'b0);
    step(3);
    check("midrst col_out held", col_out, 4'b1110);
    rst_n = 1'b1;
    check("post-rst col_out", col_out, 4'b1110);
    step(SCAN);
    check("post-rst 1 scan key_held", key_held, 1'b0);
    step(SCAN);
    check("post-rst 2 scans key_held", key_held, 1'b1);
    step(SCAN);
    check("post-rst key_valid", key_valid, 1'b1);
    check("post-rst key_code", key_code, 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of keypad rows.
REQ-002 SHALL have parameter COLS, default 4, number of keypad columns.
REQ-003 SHALL have parameter SCAN_DIV, default 62500, clk cycles each column is driven.
REQ-004 SHALL have parameter DEBOUNCE, default 2, consecutive identical full scans needed to accept a state.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, buffered key events (power of two).
REQ-006 SHALL have localparam KEY_W = clog2(ROWS*COLS).
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 row_in  input  ROWS  keypad rows, active-low, asynchronous to clk.
REQ-010 col_out  output  COLS  column drive, active-low one-hot.
REQ-011 key_code  output  KEY_W  FIFO head key code.
REQ-012 key_valid  output  1  FIFO non-empty.
REQ-013 key_ready  input  1  consumer pops head when key_valid & key_ready.
REQ-014 key_held  output  1  debounced single key currently pressed.
REQ-015 multi_key  output  1  debounced state has more than one key pressed.
REQ-016 overflow  output  1  one-cycle pulse, event dropped because FIFO full.

Function
REQ-017 row_in SHALL pass through a 2-flop synchroniser before use.
REQ-018 Column c active SHALL mean col_out[c]=0, all other bits 1; columns advance 0..COLS-1 and wrap to 0 every SCAN_DIV cycles.
REQ-019 Rows SHALL be sampled on the last cycle of each column period; a row bit of 0 marks key (r,c) pressed.
REQ-020 Key code SHALL be r*COLS + c, width KEY_W.
REQ-021 At end of each full scan the matrix SHALL classify as NONE (0 keys), SINGLE(code) (1 key) or MULTI (>1 keys).
REQ-022 Classification SHALL become the debounced state only after DEBOUNCE consecutive identical scans; any differing scan restarts the count.
REQ-023 Debounced transition to SINGLE(k) from NONE, MULTI or SINGLE(j≠k) SHALL push k into the FIFO exactly once; key held longer SHALL push nothing further.
REQ-024 Debounced MULTI SHALL set multi_key=1 and push nothing; key_held=1 only in SINGLE.
REQ-025 Push SHALL occur the cycle after the accepting scan ends; key_valid SHALL rise the following cycle.
REQ-026 Push when full and no pop SHALL drop the event and pulse overflow for one cycle; push and pop together when full SHALL both succeed.
REQ-027 Pop when empty SHALL be ignored; key_code SHALL be 0 when empty.
REQ-028 FIFO order SHALL be first-in first-out, pointers wrap modulo FIFO_DEPTH.

Reset
REQ-029 While rst_n=0: col_out={all 1, bit0=0}, divider and column counter 0, debounce state NONE with count 0, FIFO empty, key_code=0, key_valid=0, key_held=0, multi_key=0, overflow=0.
REQ-030 Reset asserted mid-scan or mid-debounce SHALL discard partial results; the first scan after release SHALL start at column 0.

Structure
REQ-031 Shared package keypad_pkg SHALL hold the scan-state enum (NONE, SINGLE, MULTI) and the KEY_W width function.
REQ-032 FIFO SHALL be the sub-module key_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/overflow).

Verification (ROWS=COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4)
REQ-033 Hold row 1 low only while column 2 is driven, for 3 scans, key_ready=1 -> exactly one key_code=6 with key_valid for one cycle; key_held=1 until release plus 2 scans.
REQ-034 Same key for 1 scan only -> no push, key_held stays 0.
REQ-035 Keys (0,0) and (3,3) for 3 scans -> multi_key=1, no push; release (3,3) -> one push of code 0.
REQ-036 key_ready=0, press codes 1,2,3,4,5 in turn -> FIFO holds 1,2,3,4, overflow pulses once on 5; drain yields 1,2,3,4.
REQ-037 FIFO full, key_ready=1 in the push cycle of a new key 9 -> no overflow, order 2,3,4,9 after popping 1.
REQ-038 rst_n low during column 2 of a debouncing press -> all outputs at reset values; col_out=1110 after release.
